// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned shift-add multiplier with HI/LO registers.
// MULTU launches a 32-cycle run; busy stalls MFHI/MFLO until commit.
module multu_hilo #(
  parameter logic [5:0] MULTU = 6'b011001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mcand;
  logic [63:0] r_prod;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_addend;
  logic [32:0] w_sum;
  logic [63:0] w_prod_nx;

  assign w_accept  = start && (Signal == MULTU);
  assign w_last    = (r_count == 5'd31);
  assign w_addend  = r_prod[0] ? {1'b0, r_mcand} : 33'd0;
  assign w_sum     = {1'b0, r_prod[63:32]} + w_addend;
  // Carry lands in bit 63, so the product stays exact.
  assign w_prod_nx = {w_sum, r_prod[31:1]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mcand <= 32'd0;
      r_prod  <= 64'd0;
      r_count <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_accept) begin
        r_mcand <= dataA;
        r_prod  <= {32'd0, dataB};
        r_count <= 5'd0;
      end else if (r_state == RUN) begin
        r_prod  <= w_prod_nx;
        r_count <= r_count + 5'd1;
        if (w_last) begin
          r_hi <= w_prod_nx[63:32];
          r_lo <= w_prod_nx[31:0];
        end
      end
    end
  end

  assign HiOut = r_hi;
  assign LoOut = r_lo;
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_multu_hilo.sv
// Scoreboard bench for multu_hilo: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_multu_hilo;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MFHI  = 6'b010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  multu_hilo #(.MULTU(F_MULTU)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Signal (Signal),
    .dataA  (dataA),
    .dataB  (dataB),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", {32'd0, HiOut}, {32'd0, e.hi});
        chk("lo", {32'd0, LoOut}, {32'd0, e.lo});
      end
    end
  end

  // Runs one multiply; optionally re-asserts start mid-RUN at cycle inj_k.
  task automatic mul(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo,
                     input int inj_k);
    int busy_cnt;
    int done_k;
    int done_cnt;
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    Signal = F_MULTU;
    dataA  = a;
    dataB  = b;
    e.hi = hi;
    e.lo = lo;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    busy_cnt = 0;
    done_k   = -1;
    done_cnt = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_k = k;
        done_cnt++;
      end
      start = (k == inj_k);
      if (k == inj_k) begin
        Signal = F_MULTU;
        dataA  = 32'd7;
        dataB  = 32'd9;
      end
    end
    start = 1'b0;
    chk("done_latency", 64'(done_k), 64'd32);
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic nonmul(input logic [5:0] f);
    @(negedge clk);
    start  = 1'b1;
    Signal = f;
    dataA  = 32'hDEAD_BEEF;
    dataB  = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("nonmul_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("nonmul_busy2", {63'd0, busy}, 64'd0);
    chk("nonmul_hilo", {HiOut, LoOut}, {m_hi, m_lo});
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    Signal = 6'd0;
    dataA  = 32'd0;
    dataB  = 32'd0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'd0, HiOut}, 64'd0);
    chk("rst_lo", {32'd0, LoOut}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    mul(32'd3, 32'd5, 32'h0, 32'hF, -1);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, -1);
    mul(32'h8000_0000, 32'd2, 32'h1, 32'h0, -1);
    chk("held_after_run", {HiOut, LoOut}, 64'h1_0000_0000);
    mul(32'h1234_5678, 32'd0, 32'h0, 32'h0, -1);

    m_hi = 32'h0;
    m_lo = 32'h0;
    mul(32'd3, 32'd5, 32'h0, 32'hF, -1);
    nonmul(F_ADD);
    nonmul(F_MFHI);

    mul(32'h10, 32'h10, 32'h0, 32'h100, 5);
    chk("retained", {HiOut, LoOut}, 64'h100);
    mul(32'd7, 32'd9, 32'h0, 32'h3F, -1);

    // Abort at iteration 10 with reset.
    @(negedge clk);
    start  = 1'b1;
    Signal = F_MULTU;
    dataA  = 32'hFFFF;
    dataB  = 32'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {HiOut, LoOut}, 64'd0);
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (40) @(negedge clk);
    chk("abort_still_idle", {63'd0, busy}, 64'd0);
    mul(32'd6, 32'd7, 32'h0, 32'h2A, -1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
